// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: generates SCLK/CS from a latched configuration and
// strobes the register bank's shift register once per sampled bit.
module spi_xfer_ctrl #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 go_bsy,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [2:0]           char_len,
  input  logic                 lsb,
  input  logic                 ie,
  input  logic                 irq_ack,
  input  logic [7:0]           trx,
  output logic                 transfer,
  output logic                 sample_en,
  output logic                 transfer_en,
  output logic                 bsy_clr,
  output logic                 sclk_pad_o,
  output logic                 cs_n_pad_o,
  output logic                 mosi_pad_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH, DONE} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_l_q, div_l_d;
  logic [4:0]           edge_cnt_q, edge_cnt_d;
  logic                 cpha_q, cpha_d;
  logic [2:0]           len_q, len_d;
  logic                 lsb_q, lsb_d;
  logic                 sclk_q, sclk_d;
  logic                 sample_q, sample_d;
  logic                 xfer_en_q, xfer_en_d;
  logic                 irq_q, irq_d;
  logic [2:0]           msb_idx;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      div_l_q    <= '0;
      edge_cnt_q <= '0;
      cpha_q     <= 1'b0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      sample_q   <= 1'b0;
      xfer_en_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_l_q    <= div_l_d;
      edge_cnt_q <= edge_cnt_d;
      cpha_q     <= cpha_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      sclk_q     <= sclk_d;
      sample_q   <= sample_d;
      xfer_en_q  <= xfer_en_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_l_d    = div_l_q;
    edge_cnt_d = edge_cnt_q;
    cpha_d     = cpha_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    sclk_d     = sclk_q;
    sample_d   = 1'b0;
    xfer_en_d  = sample_q;
    irq_d      = irq_ack ? 1'b0 : irq_q;
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (go_bsy) begin
          div_l_d    = divider;
          cpha_d     = cpha;
          len_d      = char_len;
          lsb_d      = lsb;
          div_cnt_d  = divider;
          edge_cnt_d = {char_len == 3'd0, char_len, 1'b0};
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (div_cnt_q == '0) begin
          div_cnt_d  = div_l_q;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q - 5'd1;
          // edge_cnt even on odd (leading) ticks because it starts at 2N
          sample_d   = (edge_cnt_q[0] == cpha_q);
          if (edge_cnt_q == 5'd1) state_d = FINISH;
        end else begin
          div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
      end
      FINISH: begin
        if (div_cnt_q == '0) state_d = DONE;
        else div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
      end
      DONE: begin
        state_d = IDLE;
        if (ie) irq_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside a transfer mosi follows the live config so the first bit is ready.
  assign msb_idx = ((state_q == IDLE) ? char_len : len_q) - 3'd1;

  assign mosi_pad_o  = ((state_q == IDLE) ? lsb : lsb_q) ? trx[0] : trx[msb_idx];
  assign transfer    = (state_q != IDLE);
  assign cs_n_pad_o  = !((state_q == ACTIVE) || (state_q == FINISH));
  assign bsy_clr     = (state_q == DONE);
  assign sclk_pad_o  = sclk_q;
  assign sample_en   = sample_q;
  assign transfer_en = xfer_en_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI register bank. It starts a transfer when ctrl.go_bsy is set, generates SCLK/CS from divider/cpol/cpha, and strobes sample_en/transfer_en so the bank's trx register captures MISO and shifts out MOSI. At completion it pulses bsy_clr to clear go_bsy and raises a maskable interrupt. It sits between reg_bank and the SPI pads.

Parameters:
DIV_WIDTH, 16, width of divider input and internal half-period counter

Ports:
pclk  input  1  system clock
presetn  input  1  asynchronous active-low reset
go_bsy  input  1  start request (ctrl bit, level)
divider  input  DIV_WIDTH  SCLK half-period = divider+1 pclk cycles
cpol  input  1  SCLK idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
char_len  input  3  bits per transfer N; 0 means 8
lsb  input  1  1: LSB first
ie  input  1  interrupt enable
irq_ack  input  1  clears irq_o
trx  input  8  shift register contents from the bank
transfer  output  1  transfer in progress (blocks register writes)
sample_en  output  1  capture-MISO strobe
transfer_en  output  1  shift-trx strobe
bsy_clr  output  1  one-cycle go_bsy clear pulse
sclk_pad_o  output  1  SPI clock
cs_n_pad_o  output  1  chip select, active low
mosi_pad_o  output  1  serial data out
irq_o  output  1  sticky interrupt

Behaviour:
- Reset values: state IDLE; transfer=0, sample_en=0, transfer_en=0, bsy_clr=0, sclk_pad_o=0, cs_n_pad_o=1, irq_o=0; all counters 0.
- States: IDLE, ACTIVE, FINISH, DONE. transfer=1 in every state except IDLE. cs_n_pad_o=0 in ACTIVE and FINISH.
- IDLE: sclk_pad_o registers cpol each cycle. If go_bsy=1: latch divider/cpol/cpha/char_len; div_cnt<=divider; edge_cnt<=2N; go to ACTIVE. Start cycle S; ACTIVE is visible from S+1.
- ACTIVE: div_cnt decrements each cycle. At div_cnt==0 (a tick): reload divider, toggle sclk (visible next cycle), decrement edge_cnt. Ticks are numbered 1..2N; odd ticks are leading edges, even ticks are trailing edges.
- Sample edge: odd ticks when cpha=0, even ticks when cpha=1. sample_en is high for the one cycle after a sample-edge tick. transfer_en is high for the one cycle after each sample_en.
- After tick 2N, go to FINISH with div_cnt=divider. Exit when div_cnt==0, then go to DONE.
- DONE lasts one cycle: bsy_clr=1; go to IDLE. go_bsy is ignored in DONE (the bank clears it on this edge). irq_o<=1 at the end of DONE if ie=1.
- Timing: last tick at S+2N(d+1), where d = divider. DONE at S+(2N+1)(d+1)+1. Last transfer_en at S+2N(d+1)+2, which is never later than DONE.
- mosi_pad_o (combinational): trx[0] when lsb=1, else trx[N-1].
- irq_o is cleared by irq_ack. If set and ack occur in the same cycle, set wins.
- Config inputs are used only through the values latched at start; changes mid-transfer have no effect.
- Reset mid-operation immediately returns all outputs to their reset values. No bsy_clr or irq is generated.
- divider=0 is legal: half-period is one pclk.
- divider=all-ones: counter must not overflow (it counts down only).

Test Plan:
- cpol=0, cpha=0, N=8, d=1, go_bsy at S: transfer high S+1..S+35; 16 sclk toggles, first visible S+3; 8 sample_en pulses, first at S+3; bsy_clr only at S+35; cs_n high at S+35.
- cpha=1, cpol=1, N=8, d=0: sclk idles at 1; sample_en follows even ticks only; last transfer_en at S+18; DONE at S+18.
- lsb=0, char_len=3, trx=8'b0000_0101 with MISO looped to MOSI: exactly 3 transfer_en pulses; mosi_pad_o starts at trx[2]=1; final trx[2:0]=101.
- ie=1: irq_o rises the cycle after bsy_clr. irq_ack and a new completion in the same cycle -> irq_o stays 1. With ie=0, irq_o stays 0.
- presetn pulsed low mid-ACTIVE -> cs_n=1, sclk=0, transfer=0, no bsy_clr; after reset with go_bsy=1, a full new transfer runs.
- divider=16'hFFFF, N=1: first tick at S+65536; no wrap; DONE at S+3·65536+1.
